connect_board_engine: RTL and testbench

Parametrised board engine for the connect-N game: accepts one column drop per handshake and keeps per-column fill heights, cell occupancy and cell ownership. It alternates players, detects a WIN_LEN line through the last placed piece over four check cycles, detects a draw, and drives two LED bits per cell. It replaces the fixed 4x4 column/selector/winner path and LED mapping. It sits between the debounced button/switch front end and the board LED ports and seven-segment status display.

---
 rtl/connect_pkg.sv | 18 +
 rtl/connect_line_counter.sv | 49 ++++
 rtl/connect_board_engine.sv | 142 ++++++++++++++
 tb/tb_connect_board_engine.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/connect_pkg.sv
// connect_pkg: shared types, status codes and board geometry helpers for the connect-N engine
package connect_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CHK_H, S_CHK_V, S_CHK_D1, S_CHK_D2, S_DONE} state_t;
  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_P0   = 2'b01;
  localparam logic [1:0] ST_P1   = 2'b10;
  localparam logic [1:0] ST_DRAW = 2'b11;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D1, DIR_D2} dir_t;
  function automatic int dir_dcol(dir_t d);
    return d == DIR_V ? 0 : 1;
  endfunction
  function automatic int dir_drow(dir_t d);
    return d == DIR_H ? 0 : d == DIR_D2 ? -1 : 1;
  endfunction
  function automatic int cell_index(int col, int row, int rows);
    return col * rows + row;
  endfunction
endpackage

// File: rtl/connect_line_counter.sv
// connect_line_counter: length of the same-owner run through one cell along one axis
module connect_line_counter
  import connect_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  localparam int N = COLS * ROWS,
  localparam int MAXL = COLS > ROWS ? COLS : ROWS,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int LW = $clog2(MAXL + 1)
) (
  input  logic [N-1:0]  i_occupied,
  input  logic [N-1:0]  i_owner,
  input  logic [CW-1:0] i_col,
  input  logic [RW-1:0] i_row,
  input  dir_t          i_dir,
  output logic [LW-1:0] o_count
);
  int   w_c, w_r, w_idx, w_cnt;
  logic w_me, w_live, w_in;
  function automatic logic bit_at(logic [N-1:0] v, int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction
  // walk outwards both ways from the cell, stopping at the first edge, gap or foreign piece
  always_comb begin
    w_c = 0;
    w_r = 0;
    w_idx = 0;
    w_in = 1'b0;
    w_live = 1'b0;
    w_me = bit_at(i_owner, cell_index(int'(i_col), int'(i_row), ROWS));
    w_cnt = 1;
    for (int s = 0; s < 2; s++) begin
      w_live = 1'b1;
      for (int k = 1; k < MAXL; k++) begin
        w_c = int'(i_col) + (s == 0 ? k : -k) * dir_dcol(i_dir);
        w_r = int'(i_row) + (s == 0 ? k : -k) * dir_drow(i_dir);
        w_in = w_c >= 0 && w_c < COLS && w_r >= 0 && w_r < ROWS;
        w_idx = w_in ? cell_index(w_c, w_r, ROWS) : 0;
        w_live = w_live && w_in && bit_at(i_occupied, w_idx) && bit_at(i_owner, w_idx) == w_me;
        w_cnt = w_cnt + (w_live ? 1 : 0);
      end
    end
    o_count = LW'(w_cnt);
  end
endmodule

// File: rtl/connect_board_engine.sv
// connect_board_engine: connect-N board state, move handshake, win/draw detection and LED drive
module connect_board_engine
  import connect_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int WIN_LEN = 4,
  localparam int N = COLS * ROWS,
  localparam int MAXL = COLS > ROWS ? COLS : ROWS,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int HW = $clog2(ROWS + 1),
  localparam int MW = $clog2(N + 1),
  localparam int LW = $clog2(MAXL + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_new_game,
  input  logic            i_drop_valid,
  input  logic [CW-1:0]   i_drop_col,
  output logic            o_drop_ready,
  output logic            o_move_ok,
  output logic            o_move_err,
  output logic            o_cur_player,
  output logic [1:0]      o_status,
  output logic [N-1:0]    o_occupied,
  output logic [N-1:0]    o_owner,
  output logic [2*N-1:0]  o_led_pairs
);
  state_t        r_state;
  logic [HW-1:0] r_height [COLS];
  logic [MW-1:0] r_moves;
  logic [CW-1:0] r_last_col;
  logic [RW-1:0] r_last_row;
  logic          r_win, r_ready, r_ok, r_err, r_player;
  logic [1:0]    r_status;
  logic [N-1:0]  r_occ, r_own;
  logic [2*N-1:0] r_led, w_led;
  logic          w_col_in, w_legal, w_hit;
  logic [HW-1:0] w_h;
  logic [LW-1:0] w_count;
  dir_t          w_dir;
  int            w_idx;
  // legality of the requested column and the target cell it would fill
  always_comb begin
    w_col_in = int'(i_drop_col) < COLS;
    w_h = w_col_in ? r_height[i_drop_col] : HW'(ROWS);
    w_legal = w_col_in && w_h < HW'(ROWS);
    w_idx = cell_index(int'(i_drop_col), int'(w_h), ROWS);
    w_dir = r_state == S_CHK_V ? DIR_V : r_state == S_CHK_D1 ? DIR_D1 : r_state == S_CHK_D2 ? DIR_D2 : DIR_H;
    w_hit = int'(w_count) >= WIN_LEN;
  end
  // per-cell LED code derived from the committed board
  always_comb begin
    w_led = '0;
    for (int i = 0; i < N; i++) w_led[2*i +: 2] = {r_occ[i] & r_own[i], r_occ[i] & ~r_own[i]};
  end
  connect_line_counter #(.COLS(COLS), .ROWS(ROWS)) u_line (
    .i_occupied(r_occ),
    .i_owner   (r_own),
    .i_col     (r_last_col),
    .i_row     (r_last_row),
    .i_dir     (w_dir),
    .o_count   (w_count)
  );
  // game FSM: accept a drop, sweep the four axes, then resolve win/draw/next player
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      for (int c = 0; c < COLS; c++) r_height[c] <= '0;
      r_moves <= '0;
      r_last_col <= '0;
      r_last_row <= '0;
      {r_win, r_ready, r_ok, r_err, r_player} <= '0;
      r_status <= ST_PLAY;
      r_occ <= '0;
      r_own <= '0;
      r_led <= '0;
    end else if (i_new_game) begin
      r_state <= S_IDLE;
      for (int c = 0; c < COLS; c++) r_height[c] <= '0;
      r_moves <= '0;
      r_last_col <= '0;
      r_last_row <= '0;
      {r_win, r_ready, r_ok, r_err, r_player} <= '0;
      r_status <= ST_PLAY;
      r_occ <= '0;
      r_own <= '0;
      r_led <= '0;
    end else begin
      r_ok <= 1'b0;
      r_err <= 1'b0;
      r_led <= w_led;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && i_drop_valid) begin
            if (w_legal) begin
              r_occ <= r_occ | (N'(1) << w_idx);
              r_own <= r_own | (N'(r_player) << w_idx);
              r_height[i_drop_col] <= w_h + 1'b1;
              r_moves <= r_moves + 1'b1;
              r_last_col <= i_drop_col;
              r_last_row <= RW'(w_h);
              r_ok <= 1'b1;
              r_ready <= 1'b0;
              r_win <= 1'b0;
              r_state <= S_CHK_H;
            end else r_err <= 1'b1;
          end
        end
        S_CHK_H, S_CHK_V, S_CHK_D1: begin
          r_win <= r_win | w_hit;
          r_state <= r_state == S_CHK_H ? S_CHK_V : r_state == S_CHK_V ? S_CHK_D1 : S_CHK_D2;
        end
        S_CHK_D2: begin
          r_win <= r_win | w_hit;
          if (r_win || w_hit) begin
            r_status <= r_player ? ST_P1 : ST_P0;
            r_state <= S_DONE;
          end else if (r_moves == MW'(N)) begin
            r_status <= ST_DRAW;
            r_state <= S_DONE;
          end else begin
            r_player <= ~r_player;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end
  assign o_drop_ready = r_ready;
  assign o_move_ok = r_ok;
  assign o_move_err = r_err;
  assign o_cur_player = r_player;
  assign o_status = r_status;
  assign o_occupied = r_occ;
  assign o_owner = r_own;
  assign o_led_pairs = r_led;
endmodule

// File: tb/tb_connect_board_engine.sv
// tb_connect_board_engine: directed scoreboard bench for a 4x4 and a 7x6 engine
module tb_connect_board_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, new_game, valid, sel;
  logic [2:0] col;
  logic a_ready, a_ok, a_err, a_pl, b_ready, b_ok, b_err, b_pl;
  logic [1:0] a_st, b_st;
  logic [15:0] a_occ, a_own;
  logic [31:0] a_led;
  logic [41:0] b_occ, b_own;
  logic [83:0] b_led;
  logic g_ready, g_ok, g_err;
  int n_checks = 0, n_fail = 0;
  logic [1:0] sb[$];
  assign g_ready = sel ? b_ready : a_ready;
  assign g_ok = sel ? b_ok : a_ok;
  assign g_err = sel ? b_err : a_err;

  connect_board_engine #(.COLS(4), .ROWS(4), .WIN_LEN(4)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_new_game(new_game), .i_drop_valid(valid & ~sel),
    .i_drop_col(col[1:0]), .o_drop_ready(a_ready), .o_move_ok(a_ok), .o_move_err(a_err),
    .o_cur_player(a_pl), .o_status(a_st), .o_occupied(a_occ), .o_owner(a_own), .o_led_pairs(a_led));
  connect_board_engine #(.COLS(7), .ROWS(6), .WIN_LEN(4)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_new_game(new_game), .i_drop_valid(valid & sel),
    .i_drop_col(col), .o_drop_ready(b_ready), .o_move_ok(b_ok), .o_move_err(b_err),
    .o_cur_player(b_pl), .o_status(b_st), .o_occupied(b_occ), .o_owner(b_own), .o_led_pairs(b_led));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!g_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!g_ready) chk("ready_timeout", g_ready, 1);
  endtask
  task automatic drop(input int c, input logic [1:0] e);
    int n;
    wait_ready(n);
    sb.push_back(e);
    col = 3'(c);
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("move_pulse", {g_ok, g_err}, sb.pop_front());
  endtask
  task automatic clear_game();
    new_game = 1'b1;
    step(1);
    new_game = 1'b0;
  endtask

  initial begin
    int n;
    int seq_h[7] = '{0, 0, 1, 0, 2, 0, 3};
    int seq_d[10] = '{1, 0, 2, 1, 3, 3, 2, 2, 3, 3};
    int seq_x[16] = '{0, 2, 2, 3, 3, 0, 0, 0, 1, 1, 1, 2, 2, 3, 3, 1};
    int seq_v[7] = '{0, 1, 0, 1, 0, 1, 0};
    reset = 1'b1; new_game = 1'b0; valid = 1'b0; sel = 1'b0; col = '0;
    #12;
    chk("rst_occ", a_occ, 0);
    chk("rst_own", a_own, 0);
    chk("rst_led", a_led, 0);
    chk("rst_status", a_st, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_player", a_pl, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("ready_release", a_ready, 0);
    step(1);
    chk("ready_after", a_ready, 1);
    drop(0, 2'b10);
    chk("occ_at_T", a_occ, 16'h0001);
    chk("led_lag_T", a_led, 0);
    step(1);
    chk("led_at_T1", a_led, 32'h1);
    chk("ready_chk", a_ready, 0);
    wait_ready(n);
    chk("latency", n, 3);
    repeat (3) drop(0, 2'b10);
    wait_ready(n);
    chk("col0_occ", a_occ[3:0], 4'b1111);
    chk("col0_own", a_own[3:0], 4'b1010);
    chk("col0_led", a_led[7:0], 8'b10_01_10_01);
    chk("col0_status", a_st, 0);
    chk("col0_player", a_pl, 0);
    repeat (4) drop(1, 2'b10);
    drop(1, 2'b01);
    chk("full_occ", a_occ, 16'h00FF);
    chk("full_own", a_own, 16'h00AA);
    chk("full_player", a_pl, 0);
    chk("full_ready", a_ready, 1);
    col = 3'd1;
    valid = 1'b1;
    repeat (2) begin
      sb.push_back(2'b01);
      step(1);
      chk("err_b2b", {a_ok, a_err}, sb.pop_front());
    end
    valid = 1'b0;
    clear_game();
    chk("ng_occ", a_occ, 0);
    chk("ng_ready", a_ready, 0);
    step(1);
    chk("ng_ready_next", a_ready, 1);
    new_game = 1'b1; valid = 1'b1; col = 3'd2;
    step(1);
    new_game = 1'b0; valid = 1'b0;
    chk("ng_vs_drop_pulse", {a_ok, a_err}, 0);
    chk("ng_vs_drop_occ", a_occ, 0);
    foreach (seq_h[i]) drop(seq_h[i], 2'b10);
    step(4);
    chk("hwin_status", a_st, 2'b01);
    chk("hwin_ready", a_ready, 0);
    chk("hwin_player", a_pl, 0);
    valid = 1'b1; col = 3'd3;
    repeat (3) begin
      step(1);
      chk("done_no_pulse", {a_ok, a_err}, 0);
    end
    valid = 1'b0;
    chk("done_occ", a_occ, 16'h111F);
    clear_game();
    chk("done_ng_status", a_st, 0);
    chk("done_ng_led", a_led, 0);
    step(1);
    chk("done_ng_ready", a_ready, 1);
    foreach (seq_d[i]) drop(seq_d[i], 2'b10);
    step(3);
    chk("dwin_T3", a_st, 2'b00);
    step(1);
    chk("dwin_T4", a_st, 2'b10);
    chk("dwin_player", a_pl, 1);
    clear_game();
    foreach (seq_x[i]) drop(seq_x[i], 2'b10);
    step(4);
    chk("draw_status", a_st, 2'b11);
    chk("draw_ready", a_ready, 0);
    chk("draw_occ", a_occ, 16'hFFFF);
    chk("draw_own", a_own, 16'h55AA);
    clear_game();
    drop(0, 2'b10);
    step(1);
    reset = 1'b1;
    #1;
    chk("midchk_occ", a_occ, 0);
    chk("midchk_own", a_own, 0);
    chk("midchk_ready", a_ready, 0);
    chk("midchk_status", a_st, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1);
    chk("midchk_ready_next", a_ready, 1);
    sel = 1'b1;
    drop(7, 2'b01);
    foreach (seq_v[i]) drop(seq_v[i], 2'b10);
    step(4);
    chk("b_status", b_st, 2'b01);
    chk("b_occ", b_occ, 42'h1CF);
    chk("b_own", b_own, 42'h1C0);
    chk("b_ready", b_ready, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
